// File: rtl/ipcore_job_arbiter_if.sv
// ---------------------------------------------------------------------------
// ipcore_job_arbiter_if
// Bundles the requester, response and core-side signals of the job arbiter.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//   DATA_WIDTH - job / result width
//
// Signals (names as seen from the arbiter):
//   req_valid_i   [NUM_REQ]            per-requester job valid
//   req_data_i    [NUM_REQ*DATA_WIDTH] job payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   [NUM_REQ]            one-hot accept strobe
//   rsp_valid_o                        response valid
//   rsp_ready_i                        response consumer ready
//   rsp_id_o      [ID_W]               requester that owns the response
//   rsp_data_o    [DATA_WIDTH]         result
//   rsp_err_o                          job failed
//   core_enable_o                      one-cycle start pulse to the core
//   core_data_o   [DATA_WIDTH]         job payload to the core
//   core_status_i [2]                  core status (IDLE/BUSY/DONE/ERROR)
//   core_data_i   [DATA_WIDTH]         core result
//   busy_o                             arbiter not idle
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding requesters, response consumer and core
// ---------------------------------------------------------------------------
interface ipcore_job_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [ID_W-1:0]               rsp_id_o;
    logic [DATA_WIDTH-1:0]         rsp_data_o;
    logic                          rsp_err_o;
    logic                          core_enable_o;
    logic [DATA_WIDTH-1:0]         core_data_o;
    logic [1:0]                    core_status_i;
    logic [DATA_WIDTH-1:0]         core_data_i;
    logic                          busy_o;

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i, core_status_i, core_data_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o,
               core_enable_o, core_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i, core_status_i, core_data_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o,
               core_enable_o, core_data_o, busy_o
    );
endinterface

// File: rtl/ipcore_job_arbiter.sv
// ---------------------------------------------------------------------------
// ipcore_job_arbiter
// Round-robin job arbiter and sequencer for the shared custom_axi_ip core.
// Grants one requester job at a time, pulses the core enable, waits for the
// core to report DONE or ERROR and returns the result tagged with the
// requester ID on a single response channel.
//
// Parameters:
//   NUM_REQ        - number of requesters, 2..8
//   DATA_WIDTH     - job / result width
//   TIMEOUT_CYCLES - watchdog limit in A_WAIT (watchdog builds only)
//
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - ipcore_job_arbiter_if.slave: requester, response and core signals
//
// Build option:
//   IPARB_WATCHDOG_EN - when defined, A_WAIT gives up after TIMEOUT_CYCLES
//                       cycles and answers with err=1, data=0.
// ---------------------------------------------------------------------------
module ipcore_job_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ipcore_job_arbiter_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ipcore_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_ISSUE = 2'd1,
        A_WAIT  = 2'd2,
        A_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } status_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0] job_q, job_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef IPARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

    status_e               status;
    logic                  any_valid;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       cand;
    logic [NUM_REQ-1:0]    req_ready;

    assign status = status_e'(bus.core_status_i);

    // Round-robin search: first valid requester starting just above the last
    // served one, so the previous winner is checked last.
    always_comb begin
        any_valid = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
            if (!any_valid && bus.req_valid_i[cand]) begin
                any_valid = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        job_d        = job_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
`ifdef IPARB_WATCHDOG_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            A_IDLE: begin
                if (any_valid) begin
                    id_d    = grant_id;
                    job_d   = bus.req_data_i[grant_id*DATA_WIDTH +: DATA_WIDTH];
                    state_d = A_ISSUE;
                end
            end
            A_ISSUE: begin
`ifdef IPARB_WATCHDOG_EN
                cnt_d   = '0;
`endif
                state_d = A_WAIT;
            end
            A_WAIT: begin
                case (status)
                    ST_DONE: begin
                        rsp_data_d = bus.core_data_i;
                        rsp_err_d  = 1'b0;
                        state_d    = A_RESP;
                    end
                    ST_ERROR: begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = A_RESP;
                    end
                    default: begin
`ifdef IPARB_WATCHDOG_EN
                        // Checked only when no DONE/ERROR arrived, so a
                        // completion in the expiry cycle still wins.
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                            state_d    = A_RESP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`endif
                    end
                endcase
            end
            A_RESP: begin
                if (bus.rsp_ready_i) begin
                    last_grant_d = id_q;
                    state_d      = A_IDLE;
                end
            end
            default: state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= A_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            job_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            job_q        <= job_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef IPARB_WATCHDOG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Accept strobe is combinational from state and valids; gated by reset so
    // every output is low while rst_ni is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_ni && state_q == A_IDLE && any_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // All remaining outputs decode from registered state, so an asynchronous
    // reset clears them immediately.
    assign bus.req_ready_o   = req_ready;
    assign bus.core_enable_o = (state_q == A_ISSUE);
    assign bus.core_data_o   = (state_q == A_ISSUE || state_q == A_WAIT) ? job_q : '0;
    assign bus.rsp_valid_o   = (state_q == A_RESP);
    assign bus.rsp_id_o      = (state_q == A_RESP) ? id_q : '0;
    assign bus.rsp_data_o    = (state_q == A_RESP) ? rsp_data_q : '0;
    assign bus.rsp_err_o     = (state_q == A_RESP) && rsp_err_q;
    assign bus.busy_o        = (state_q != A_IDLE);

endmodule

// File: tb/tb_ipcore_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ipcore_job_arbiter
// Directed bench for ipcore_job_arbiter (NUM_REQ=4, DATA_WIDTH=32,
// TIMEOUT_CYCLES=16). The core is modelled by driving core_status_i and
// core_data_i directly from the stimulus. Builds with or without
// IPARB_WATCHDOG_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ipcore_job_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ipcore_job_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    ipcore_job_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int e0;
    int k;
    int seen;

    // Counts cycles in which the start pulse is high.
    always @(negedge clk) begin
        if (bus.core_enable_o === 1'b1) en_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int unsigned r, input logic [31:0] d);
        bus.req_data_i[r*DW +: DW] = d;
    endtask

    // Runs one job from the grant cycle to the response handshake; the core
    // answers after nbusy BUSY cycles in A_WAIT.
    task automatic do_job(input string tag, input int unsigned id, input logic [31:0] job,
                          input int unsigned nbusy, input logic is_err,
                          input logic [31:0] res, input bit drop);
        int e_start;
        check_eq({tag, "_grant"}, 64'(bus.req_ready_o), 64'(1 << id));
        check_eq({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
        e_start = en_cnt;
        tick();
        if (drop) bus.req_valid_i[id] = 1'b0;
        check_eq({tag, "_issue_en"}, 64'(bus.core_enable_o), 64'd1);
        check_eq({tag, "_issue_data"}, 64'(bus.core_data_o), 64'(job));
        check_eq({tag, "_issue_ready"}, 64'(bus.req_ready_o), 64'd0);
        check_eq({tag, "_issue_busy"}, 64'(bus.busy_o), 64'd1);
        tick();
        check_eq({tag, "_wait_en"}, 64'(bus.core_enable_o), 64'd0);
        check_eq({tag, "_wait_data"}, 64'(bus.core_data_o), 64'(job));
        check_eq({tag, "_pulses"}, 64'(en_cnt - e_start), 64'd1);
        repeat (nbusy) begin
            bus.core_status_i = 2'd1;
            tick();
            check_eq({tag, "_wait_rsp"}, 64'(bus.rsp_valid_o), 64'd0);
        end
        bus.core_status_i = is_err ? 2'd3 : 2'd2;
        bus.core_data_i   = is_err ? 32'hDEAD_BEEF : res;
        tick();
        bus.core_status_i = 2'd0;
        bus.core_data_i   = '0;
        check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1);
        check_eq({tag, "_rsp_id"}, 64'(bus.rsp_id_o), 64'(id));
        check_eq({tag, "_rsp_data"}, 64'(bus.rsp_data_o), is_err ? 64'd0 : 64'(res));
        check_eq({tag, "_rsp_err"}, 64'(bus.rsp_err_o), 64'(is_err));
        check_eq({tag, "_rsp_ready"}, 64'(bus.req_ready_o), 64'd0);
        tick();
        check_eq({tag, "_after_hs"}, 64'(bus.rsp_valid_o), 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        check_eq({tag, "_en"}, 64'(bus.core_enable_o), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check_eq({tag, "_core_data"}, 64'(bus.core_data_o), 64'd0);
        check_eq({tag, "_ready"}, 64'(bus.req_ready_o), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid_i   = '0;
        bus.req_data_i    = '0;
        bus.rsp_ready_i   = 1'b1;
        bus.core_status_i = 2'd0;
        bus.core_data_i   = '0;

        // Reset state, with all requesters asking: nothing may be accepted.
        bus.req_valid_i = 4'b1111;
        #2;
        check_eq("rst_ready", 64'(bus.req_ready_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check_eq("rst_en", 64'(bus.core_enable_o), 64'd0);
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_core_data", 64'(bus.core_data_o), 64'd0);
        check_eq("rst_rsp_id", 64'(bus.rsp_id_o), 64'd0);
        check_eq("rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
        check_eq("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
        repeat (2) tick();
        bus.req_valid_i = '0;
        rst_n = 1'b1;
        #1;

        // Single job from requester 1, DONE two cycles after the enable.
        set_job(1, 32'h0000_00A5);
        bus.req_valid_i = 4'b0010;
        #1;
        do_job("single", 1, 32'h0000_00A5, 1, 1'b0, 32'h0000_00A6, 1'b1);

        // Round robin from reset with all four requesters held valid.
        apply_reset("rr_rst");
        for (int unsigned r = 0; r < NR; r++) set_job(r, 32'h1000_0000 | r);
        bus.req_valid_i = 4'b1111;
        #1;
        do_job("rr0", 0, 32'h1000_0000, 0, 1'b0, 32'h2000_0000, 1'b0);
        do_job("rr1", 1, 32'h1000_0001, 0, 1'b0, 32'h2000_0001, 1'b0);
        do_job("rr2", 2, 32'h1000_0002, 0, 1'b0, 32'h2000_0002, 1'b0);
        do_job("rr3", 3, 32'h1000_0003, 0, 1'b0, 32'h2000_0003, 1'b0);
        do_job("rr4", 0, 32'h1000_0000, 0, 1'b0, 32'h2000_0010, 1'b0);
        bus.req_valid_i = '0;
        #1;

        // Core ERROR on requester 2; the next tie starts at requester 3.
        set_job(2, 32'h0000_0222);
        bus.req_valid_i = 4'b0100;
        #1;
        do_job("err2", 2, 32'h0000_0222, 2, 1'b1, 32'h0, 1'b1);
        bus.req_valid_i = 4'b1111;
        #1;
        do_job("after_err", 3, 32'h1000_0003, 0, 1'b0, 32'h0000_0033, 1'b0);
        bus.req_valid_i = '0;
        #1;

        // Response backpressure for 10 cycles.
        bus.req_valid_i = 4'b0001;
        #1;
        check_eq("bp_grant", 64'(bus.req_ready_o), 64'b0001);
        tick();
        bus.req_valid_i = '0;
        tick();
        bus.core_status_i = 2'd2;
        bus.core_data_i   = 32'h0000_0055;
        tick();
        bus.core_status_i = 2'd0;
        bus.core_data_i   = '0;
        bus.rsp_ready_i   = 1'b0;
        bus.req_valid_i   = 4'b1111;
        e0 = en_cnt;
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
            check_eq("bp_id", 64'(bus.rsp_id_o), 64'd0);
            check_eq("bp_data", 64'(bus.rsp_data_o), 64'h55);
            check_eq("bp_err", 64'(bus.rsp_err_o), 64'd0);
            check_eq("bp_ready", 64'(bus.req_ready_o), 64'd0);
            tick();
        end
        check_eq("bp_no_pulse", 64'(en_cnt - e0), 64'd0);
        bus.rsp_ready_i = 1'b1;
        tick();
        check_eq("bp_released", 64'(bus.rsp_valid_o), 64'd0);
        check_eq("bp_next_grant", 64'(bus.req_ready_o), 64'b0010);
        bus.req_valid_i = '0;
        #1;

        // Core stuck in BUSY on a job from requester 3.
        set_job(3, 32'h0000_3333);
        bus.req_valid_i = 4'b1000;
        #1;
        check_eq("stuck_grant", 64'(bus.req_ready_o), 64'b1000);
        tick();
        bus.req_valid_i = '0;
        tick();
        bus.core_status_i = 2'd1;
`ifdef IPARB_WATCHDOG_EN
        k = 0;
        while (bus.rsp_valid_o !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check_eq("wd_latency", 64'(k), 64'd17);
        check_eq("wd_err", 64'(bus.rsp_err_o), 64'd1);
        check_eq("wd_data", 64'(bus.rsp_data_o), 64'd0);
        check_eq("wd_id", 64'(bus.rsp_id_o), 64'd3);
        tick();
        check_eq("wd_released", 64'(bus.rsp_valid_o), 64'd0);
        // Bring another job into A_WAIT for the reset check below.
        bus.req_valid_i = 4'b0001;
        #1;
        tick();
        bus.req_valid_i = '0;
        tick();
`else
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.rsp_valid_o === 1'b1) seen++;
        end
        check_eq("nowd_no_rsp", 64'(seen), 64'd0);
`endif
        check_eq("wait_busy", 64'(bus.busy_o), 64'd1);

        // Reset during A_WAIT: outputs clear at once.
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("mid_rst_core_data", 64'(bus.core_data_o), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check_eq("mid_rst_err", 64'(bus.rsp_err_o), 64'd0);
        bus.core_status_i = 2'd0;
        tick();
        rst_n = 1'b1;
        set_job(0, 32'h0000_00A0);
        set_job(3, 32'h0000_00A3);
        bus.req_valid_i = 4'b1001;
        #1;
        check_eq("post_rst_tie", 64'(bus.req_ready_o), 64'b0001);

        // Reset during A_ISSUE drops the start pulse immediately.
        tick();
        check_eq("issue_en", 64'(bus.core_enable_o), 64'd1);
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        #1;
        check_eq("issue_rst_en", 64'(bus.core_enable_o), 64'd0);
        check_eq("issue_rst_core_data", 64'(bus.core_data_o), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("final_busy", 64'(bus.busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ipcore_job_arbiter.md
# ipcore_job_arbiter

Round-robin job arbiter and sequencer for the shared `custom_axi_ip` processing core. Up to `NUM_REQ` requesters submit 32-bit jobs. The arbiter grants one job at a time and drives the core's enable/data inputs. It then watches the core's status output until DONE or ERROR and returns the result, tagged with the requester ID, on a single response channel. It sits between the register-slave/DMA requesters and the core instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, default 32: job and result width.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in WAIT state; only used when the watchdog is compiled in.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID (localparam).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  `NUM_REQ`  per-requester job valid.
- `req_data_i`  in  `NUM_REQ*DATA_WIDTH`  job payloads; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready_o`  out  `NUM_REQ`  one-hot accept strobe.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_id_o`  out  `ID_W`  requester index that owns the response.
- `rsp_data_o`  out  `DATA_WIDTH`  result.
- `rsp_err_o`  out  1  job failed (core ERROR, or watchdog timeout).
- `core_enable_o`  out  1  one-cycle start pulse to the core.
- `core_data_o`  out  `DATA_WIDTH`  job payload to the core.
- `core_status_i`  in  2  core status; IDLE=0, BUSY=1, DONE=2, ERROR=3.
- `core_data_i`  in  `DATA_WIDTH`  core result; valid only while status is DONE.
- `busy_o`  out  1  high in every state except A_IDLE.

## Operation
- FSM states: A_IDLE, A_ISSUE, A_WAIT, A_RESP.
- **A_IDLE:**
  - If any `req_valid_i` is set, the arbiter grants the first set bit searching upward from `last_grant+1` (wrapping modulo `NUM_REQ`).
  - `req_ready_o[g]` is high in that same cycle, combinational from state and `req_valid_i`.
  - The arbiter latches `req_data_i` slice g and the ID g, then moves to A_ISSUE.
  - No valid bits means the FSM stays in A_IDLE.
- **A_ISSUE:** `core_enable_o`=1 for exactly this one cycle; `core_data_o` = latched job. Next state is A_WAIT.
- **A_WAIT:** `core_data_o` holds the job and `core_enable_o`=0. The arbiter samples `core_status_i` every cycle:
  - DONE: latch `core_data_i`, set err=0, go to A_RESP.
  - ERROR: latch data=0, set err=1, go to A_RESP.
  - IDLE or BUSY: stay in A_WAIT.
- **A_RESP:**
  - `rsp_valid_o`=1 with ID, data and err held stable until `rsp_ready_i`=1.
  - On the handshake, `last_grant` takes the granted ID and the FSM returns to A_IDLE.
  - `req_ready_o` stays all-zero in A_RESP; there is no job pipelining.
- **Fairness:** after reset `last_grant` = `NUM_REQ-1`, so requester 0 wins the first tie. A requester that was just served has the lowest priority in the next arbitration.
- **Requester rules:** a requester holds `req_valid_i` and its data until it sees its `req_ready_o` bit. Dropping valid before the grant is legal; the request is simply not considered.
- **Reset:**
  - All outputs are 0, FSM in A_IDLE, `last_grant` = `NUM_REQ-1`, watchdog counter 0.
  - Reset asserted mid-job abandons the job immediately; no response is produced and `core_enable_o` drops asynchronously.

## Timing
- Request accepted in cycle T (ready high). `core_enable_o` is high in T+1. The arbiter samples status from T+2 onward.
- Status DONE/ERROR sampled in cycle S gives `rsp_valid_o` from S+1.
- Next acceptance happens no earlier than the cycle after the response handshake.
- Minimum turnaround is 4 cycles per job when the core reports DONE at T+2 and `rsp_ready_i` is tied high.
- Simultaneous events:
  - Status DONE and watchdog expiry in the same cycle: DONE wins.
  - `rsp_ready_i` high while `rsp_valid_o` is low: ignored.

## Configuration
- `IPARB_WATCHDOG_EN` defined:
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits clears on entry to A_WAIT and increments each cycle in A_WAIT.
  - When it reaches `TIMEOUT_CYCLES` without DONE or ERROR, the FSM goes to A_RESP with err=1 and data=0.
- `IPARB_WATCHDOG_EN` not defined: no counter exists, and A_WAIT waits indefinitely for DONE or ERROR.

## Test plan
- Single job: req 1 valid with 0x0000_00A5; core returns DONE with 0x0000_00A6 two cycles after enable → `rsp_id_o`=1, data 0x0000_00A6, err=0; one enable pulse only.
- All four requesters valid continuously, `rsp_ready_i`=1 → grant order 0,1,2,3,0; each response ID matches its payload.
- Core reports ERROR on a job from req 2 → `rsp_err_o`=1, `rsp_data_o`=0, ID 2; the next arbitration starts from requester 3.
- Response backpressure: `rsp_ready_i`=0 for 10 cycles → `rsp_valid_o` and the response fields stay stable, `req_ready_o`=0, and no new enable pulse occurs.
- With `IPARB_WATCHDOG_EN` and `TIMEOUT_CYCLES`=16, core stuck in BUSY → response err=1 exactly 17 cycles after entering A_WAIT. Without the macro, no response ever arrives.
- `rst_ni` pulsed low during A_WAIT → all outputs 0 immediately; after release, requester 0 wins a 0/3 tie.
